rega_countdown_mmss: RTL and testbench
======================================

// Module: rega_countdown_mmss
// PURPOSE
// - Irrigation countdown stage. Sits directly downstream of the preset/clear generator.
// - Loads a 4-digit BCD MM:SS preset (DM,UM,DS,US) and counts it down to 00:00 at 1 Hz.
// - Holds the valve open while running; pulses done when the time expires.
// - Digits feed the 7-segment display decoders.
// PARAMETERS
// - TICK_DIV  50_000_000  clk cycles per counted second (>=2); sims use 4
// - PW        26          prescaler width; must hold TICK_DIV-1
// PORTS
// - clk       in   1  single system clock, rising edge
// - rst       in   1  asynchronous, active-high reset
// - load      in   1  1-cycle pulse: capture preset digits, (re)start
// - enable    in   1  1 = counting allowed; 0 = pause (digits held)
// - abort     in   1  force 00:00 and idle, no done pulse
// - preset_dm in   4  BCD tens of minutes
// - preset_um in   4  BCD units of minutes
// - preset_ds in   4  BCD tens of seconds
// - preset_us in   4  BCD units of seconds
// - dig_dm    out  4  current tens of minutes
// - dig_um    out  4  current units of minutes
// - dig_ds    out  4  current tens of seconds
// - dig_us    out  4  current units of seconds
// - valve     out  1  1 while in RUN or PAUSE
// - done      out  1  1-cycle pulse when count reaches 00:00 from RUN
// BEHAVIOUR
// - Reset: all digits 0, valve 0, done 0, prescaler 0, state IDLE.
// - Reset asserted mid-count: immediate clear, same values; no done pulse.
// - FSM states: IDLE, RUN, PAUSE, DONE.
// - IDLE->RUN on load with a nonzero clamped preset.
// - IDLE stays IDLE on load of 00:00: digits 0, no done pulse.
// - RUN->PAUSE when enable=0; PAUSE->RUN when enable=1.
// - RUN->DONE on the tick that makes all digits 0.
// - DONE->IDLE after exactly 1 cycle; done=1 only in DONE.
// - Load clamp, registered on the load edge: US,UM,DM >9 -> 9; DS >5 -> 5.
// - Prescaler: counts 0..TICK_DIV-1 only in RUN; tick = (count==TICK_DIV-1).
//   - Prescaler is cleared on load, on abort and in PAUSE, so each second after a resume is full length.
//   - First decrement occurs TICK_DIV cycles after load.
// - Decrement on tick, with borrow chain:
//   - US 0->9 borrows from DS; DS 0->5 borrows from UM.
//   - UM 0->9 borrows from DM; DM decrements without wrap.
// - Priority in the same cycle: rst > abort > load > tick > enable change.
// - load in RUN, PAUSE or DONE: restart from the new preset; prescaler cleared; no done pulse.
//   - A load coinciding with the final tick wins: no DONE.
// - abort in any state: digits 0, IDLE, valve 0, done 0.
// - valve is registered; changes the cycle after the state change.
// STRUCTURE
// - Shared package rega_timer_pkg: state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//   and digit maxima (US_MAX=9, DS_MAX=5, UM_MAX=9, DM_MAX=9).
// - One sub-module: rega_bcd_digit_down (param MAX)
//   - ports: clk, rst, ld, ld_val, dec, q, borrow_out
//   - instantiated 4x; borrow_out = dec & (q==0).
// - Prescaler and FSM stay in the top module.
// TESTING (TICK_DIV=4)
// - Reset: rst=1 mid-run -> all digits 0, valve 0, done 0 immediately, asynchronously.
// - Basic: load 00:03, enable=1 -> 00:02 at cycle 4, 00:01 at 8, 00:00 at 12;
//   done=1 for 1 cycle; then valve=0.
// - Borrow chain: load 10:00 -> after 1 tick 09:59; load 01:00 -> 00:59.
// - Clamp: load DM=C, UM=A, DS=7, US=F -> digits read 99:59.
// - Pause: load 00:02, drop enable for 10 cycles after 2 cycles
//   -> digits frozen, valve=1; resume -> 00:01 four cycles after resume.
// - Collisions:
//   - abort during RUN -> 00:00, valve 0, no done.
//   - load 00:05 on the cycle of the final tick -> 00:05, RUN, no done.
//   - load 00:00 -> stays IDLE, no done.

Source files
------------

// File: rtl/rega_timer_pkg.sv
// Shared definitions for the irrigation countdown timer: FSM encoding,
// per-digit BCD maxima and the preset clamp helper.
// No ports; imported by the countdown top, its digit counters and the interface users.
package rega_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int US_MAX = 9;
  localparam int DS_MAX = 5;
  localparam int UM_MAX = 9;
  localparam int DM_MAX = 9;

  // Out-of-range preset digits saturate to the digit's maximum.
  function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/rega_countdown_mmss_if.sv
// Control/preset/display bundle for the MM:SS countdown stage.
// master: preset/clear generator side (drives load/enable/abort/presets, reads digits/valve/done).
// slave:  countdown stage side (reads controls and presets, drives digits/valve/done).
interface rega_countdown_mmss_if;
  logic       load;
  logic       enable;
  logic       abort;
  logic [3:0] preset_dm;
  logic [3:0] preset_um;
  logic [3:0] preset_ds;
  logic [3:0] preset_us;
  logic [3:0] dig_dm;
  logic [3:0] dig_um;
  logic [3:0] dig_ds;
  logic [3:0] dig_us;
  logic       valve;
  logic       done;

  modport master (
    output load, enable, abort, preset_dm, preset_um, preset_ds, preset_us,
    input  dig_dm, dig_um, dig_ds, dig_us, valve, done
  );

  modport slave (
    input  load, enable, abort, preset_dm, preset_um, preset_ds, preset_us,
    output dig_dm, dig_um, dig_ds, dig_us, valve, done
  );
endinterface

// File: rtl/rega_bcd_digit_down.sv
// One BCD down-counting digit with clamped load and borrow output.
// Ports: clk, rst (async high), ld/ld_val (load clamped value), dec (count down one),
//        q (current digit), borrow_out (dec while at 0: next digit must decrement).
module rega_bcd_digit_down
  import rega_timer_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       dec,
  output logic [3:0] q,
  output logic       borrow_out
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = clamp_digit(ld_val, MAX_V);
    end else if (dec) begin
      q_d = (q_q == 4'd0) ? MAX_V : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = dec & (q_q == 4'd0);

endmodule

// File: rtl/rega_countdown_mmss.sv
// Irrigation countdown: loads an MM:SS BCD preset and counts to 00:00 once per
// TICK_DIV clocks, holding the valve open while running/paused and pulsing done at expiry.
// Ports: clk, rst (async high), bus (slave: load/enable/abort/presets in; digits/valve/done out).
module rega_countdown_mmss
  import rega_timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int PW       = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  rega_countdown_mmss_if.slave bus
);

  localparam logic [PW-1:0] CNT_LAST = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          valve_q, valve_d;

  logic [3:0] dm, um, ds, us;
  logic       tick, final_tick, preset_nz, ld_all, dec_us;
  logic       bor_us, bor_ds, bor_um, bor_dm_unused;
  logic [3:0] ld_dm, ld_um, ld_ds, ld_us;

  assign tick       = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
  // Only 00:01 reaches 00:00 on a single decrement.
  assign final_tick = tick && (dm == 4'd0) && (um == 4'd0) && (ds == 4'd0) && (us == 4'd1);
  // Clamping only lowers digits above their maximum (never to 0), so a
  // nonzero raw preset is also a nonzero clamped preset.
  assign preset_nz  = |{bus.preset_dm, bus.preset_um, bus.preset_ds, bus.preset_us};

  // Abort reuses the digit load path with zeros; both override a tick.
  assign ld_all = bus.abort | bus.load;
  assign ld_dm  = bus.abort ? 4'd0 : bus.preset_dm;
  assign ld_um  = bus.abort ? 4'd0 : bus.preset_um;
  assign ld_ds  = bus.abort ? 4'd0 : bus.preset_ds;
  assign ld_us  = bus.abort ? 4'd0 : bus.preset_us;
  assign dec_us = tick & ~ld_all;

  rega_bcd_digit_down #(.MAX(US_MAX)) u_us (
    .clk(clk), .rst(rst), .ld(ld_all), .ld_val(ld_us), .dec(dec_us),
    .q(us), .borrow_out(bor_us)
  );
  rega_bcd_digit_down #(.MAX(DS_MAX)) u_ds (
    .clk(clk), .rst(rst), .ld(ld_all), .ld_val(ld_ds), .dec(bor_us),
    .q(ds), .borrow_out(bor_ds)
  );
  rega_bcd_digit_down #(.MAX(UM_MAX)) u_um (
    .clk(clk), .rst(rst), .ld(ld_all), .ld_val(ld_um), .dec(bor_ds),
    .q(um), .borrow_out(bor_um)
  );
  // Tens of minutes never borrows: the count stops at 00:00 before it could.
  rega_bcd_digit_down #(.MAX(DM_MAX)) u_dm (
    .clk(clk), .rst(rst), .ld(ld_all), .ld_val(ld_dm), .dec(bor_um),
    .q(dm), .borrow_out(bor_dm_unused)
  );

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else if (bus.load) begin
      state_d = preset_nz ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_RUN: begin
          if (final_tick) begin
            state_d = ST_DONE;
          end else if (!bus.enable) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: if (bus.enable) state_d = ST_RUN;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // The prescaler only advances while staying in RUN; any entry into RUN
  // (load or resume) starts a fresh, full-length second.
  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && !ld_all) begin
      cnt_d = tick ? '0 : cnt_q + PW'(1);
    end
  end

  // Valve follows the state with one cycle of lag; abort shuts it at once.
  always_comb begin
    valve_d = !bus.abort && ((state_q == ST_RUN) || (state_q == ST_PAUSE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valve_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valve_q <= valve_d;
    end
  end

  assign bus.dig_dm = dm;
  assign bus.dig_um = um;
  assign bus.dig_ds = ds;
  assign bus.dig_us = us;
  assign bus.valve  = valve_q;
  assign bus.done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_rega_countdown_mmss.sv
// Directed bench for the MM:SS countdown with a 4-clock second.
// No ports; drives the interface instance and checks digits/valve/done.
module tb_rega_countdown_mmss;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rega_countdown_mmss_if bus ();

  rega_countdown_mmss #(.TICK_DIV(4), .PW(26)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] digs;
  assign digs = {bus.dig_dm, bus.dig_um, bus.dig_ds, bus.dig_us};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit after the last one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [3:0] dm, input logic [3:0] um,
                         input logic [3:0] ds, input logic [3:0] us);
    bus.preset_dm = dm;
    bus.preset_um = um;
    bus.preset_ds = ds;
    bus.preset_us = us;
    bus.load      = 1'b1;
    cyc(1);
    bus.load      = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.load      = 1'b0;
    bus.enable    = 1'b1;
    bus.abort     = 1'b0;
    bus.preset_dm = 4'd0;
    bus.preset_um = 4'd0;
    bus.preset_ds = 4'd0;
    bus.preset_us = 4'd0;
    cyc(2);
    check("rst_digits", 32'(digs), 32'h0000);
    check("rst_valve",  32'(bus.valve), 32'd0);
    check("rst_done",   32'(bus.done), 32'd0);
    rst = 1'b0;
    cyc(1);

    // Basic 00:03 countdown.
    do_load(4'd0, 4'd0, 4'd0, 4'd3);
    check("basic_load", 32'(digs), 32'h0003);
    cyc(1);
    check("basic_valve_on", 32'(bus.valve), 32'd1);
    cyc(2);
    check("basic_c3", 32'(digs), 32'h0003);
    cyc(1);
    check("basic_c4", 32'(digs), 32'h0002);
    cyc(4);
    check("basic_c8", 32'(digs), 32'h0001);
    cyc(3);
    check("basic_c11_done", 32'(bus.done), 32'd0);
    cyc(1);
    check("basic_c12", 32'(digs), 32'h0000);
    check("basic_c12_done", 32'(bus.done), 32'd1);
    check("basic_c12_valve", 32'(bus.valve), 32'd1);
    cyc(1);
    check("basic_c13_done", 32'(bus.done), 32'd0);
    check("basic_c13_valve", 32'(bus.valve), 32'd0);

    // Full borrow chain, then a reload while running.
    do_load(4'd1, 4'd0, 4'd0, 4'd0);
    cyc(4);
    check("borrow_1000", 32'(digs), 32'h0959);
    check("borrow_valve", 32'(bus.valve), 32'd1);
    do_load(4'd0, 4'd1, 4'd0, 4'd0);
    check("reload_0100", 32'(digs), 32'h0100);
    cyc(4);
    check("borrow_0100", 32'(digs), 32'h0059);

    // Clamp of out-of-range preset digits.
    do_load(4'hC, 4'hA, 4'd7, 4'hF);
    check("clamp_load", 32'(digs), 32'h9959);
    cyc(4);
    check("clamp_tick", 32'(digs), 32'h9958);

    // Abort during RUN.
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    check("abort_digits", 32'(digs), 32'h0000);
    check("abort_valve",  32'(bus.valve), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_done", 32'(bus.done), 32'd0);
      cyc(1);
    end
    check("abort_idle_valve", 32'(bus.valve), 32'd0);

    // Pause for 10 cycles, then resume.
    do_load(4'd0, 4'd0, 4'd0, 4'd2);
    cyc(2);
    bus.enable = 1'b0;
    cyc(6);
    check("pause_frozen_a", 32'(digs), 32'h0002);
    check("pause_valve_a",  32'(bus.valve), 32'd1);
    cyc(4);
    check("pause_frozen_b", 32'(digs), 32'h0002);
    check("pause_valve_b",  32'(bus.valve), 32'd1);
    bus.enable = 1'b1;
    cyc(4);
    check("resume_c3", 32'(digs), 32'h0002);
    cyc(1);
    check("resume_c4", 32'(digs), 32'h0001);

    // Load coinciding with the final tick wins.
    cyc(3);
    bus.preset_dm = 4'd0;
    bus.preset_um = 4'd0;
    bus.preset_ds = 4'd0;
    bus.preset_us = 4'd5;
    bus.load      = 1'b1;
    cyc(1);
    bus.load      = 1'b0;
    check("coll_digits", 32'(digs), 32'h0005);
    check("coll_done_a", 32'(bus.done), 32'd0);
    cyc(1);
    check("coll_done_b", 32'(bus.done), 32'd0);
    check("coll_valve",  32'(bus.valve), 32'd1);
    cyc(3);
    check("coll_running", 32'(digs), 32'h0004);

    // Load of 00:00 from IDLE stays idle.
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    do_load(4'd0, 4'd0, 4'd0, 4'd0);
    check("zero_digits", 32'(digs), 32'h0000);
    check("zero_done_a", 32'(bus.done), 32'd0);
    cyc(1);
    check("zero_done_b", 32'(bus.done), 32'd0);
    check("zero_valve",  32'(bus.valve), 32'd0);
    cyc(4);
    check("zero_idle_valve", 32'(bus.valve), 32'd0);

    // Asynchronous reset mid-count.
    do_load(4'd0, 4'd0, 4'd1, 4'd0);
    cyc(2);
    check("arst_pre_valve", 32'(bus.valve), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_digits", 32'(digs), 32'h0000);
    check("arst_valve",  32'(bus.valve), 32'd0);
    check("arst_done",   32'(bus.done), 32'd0);
    cyc(1);
    rst = 1'b0;
    cyc(5);
    check("arst_idle_digits", 32'(digs), 32'h0000);
    check("arst_idle_valve",  32'(bus.valve), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
